// File: rtl/hls_run_sequencer.sv
// rtl/hls_run_sequencer.sv - run sequencer for one Bambu accelerator: preload, start/done with watchdog, readback
module hls_run_sequencer #(
    parameter int CH_ADDR_W   = 7,
    parameter int CH_DATA_W   = 8,
    parameter int CH_SIZE_W   = 4,
    parameter int TIMEOUT_CYC = 200000000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [CH_ADDR_W-1:0]     cfg_base,
    input  logic [15:0]              cfg_load_len,
    input  logic [15:0]              cfg_read_len,
    input  logic [CH_DATA_W-1:0]     load_data,
    input  logic                     load_valid,
    output logic                     load_ready,
    output logic [CH_DATA_W-1:0]     rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic                     start_port,
    input  logic                     done_port,
    output logic [1:0]               S_oe_ram,
    output logic [1:0]               S_we_ram,
    output logic [2*CH_ADDR_W-1:0]   S_addr_ram,
    output logic [2*CH_DATA_W-1:0]   S_Wdata_ram,
    output logic [2*CH_SIZE_W-1:0]   S_data_ram_size,
    input  logic [2*CH_DATA_W-1:0]   Sout_Rdata_ram,
    input  logic [1:0]               Sout_DataRdy,
    output logic                     busy,
    output logic                     run_done,
    output logic                     timeout_flag,
    output logic [31:0]              cycle_count
);

    typedef enum logic [3:0] {
        IDLE, LOAD, LOAD_WAIT, START, RUN, READ_REQ, READ_WAIT, READ_OUT, DONE
    } state_t;

    state_t                 state, next_state;
    logic [CH_ADDR_W-1:0]   base_q;
    logic [15:0]            load_len_q;
    logic [15:0]            read_len_q;
    logic [15:0]            idx;
    logic [15:0]            idx_inc;
    logic [31:0]            wdog;
    logic                   wdog_expired;
    logic                   we0;
    logic                   oe0;
    logic [CH_ADDR_W-1:0]   ch0_addr;
    logic                   unused_inputs;

    // Channel 1 is never used, so its return lanes are deliberately ignored.
    assign unused_inputs = ^{Sout_Rdata_ram[2*CH_DATA_W-1:CH_DATA_W], Sout_DataRdy[1]};

    assign idx_inc      = idx + 16'd1;
    assign ch0_addr     = base_q + idx[CH_ADDR_W-1:0];
    assign wdog_expired = (wdog == 32'(TIMEOUT_CYC - 1));

    always_comb begin
        next_state = state;
        we0        = 1'b0;
        oe0        = 1'b0;
        case (state)
            IDLE:      if (cfg_valid) next_state = (cfg_load_len != 16'd0) ? LOAD : START;
            LOAD:      if (load_valid) begin
                           we0        = 1'b1;
                           next_state = LOAD_WAIT;
                       end
            LOAD_WAIT: if (Sout_DataRdy[0]) next_state = (idx_inc == load_len_q) ? START : LOAD;
            START:     next_state = RUN;
            RUN:       if (done_port) next_state = (read_len_q != 16'd0) ? READ_REQ : DONE;
                       else if (wdog_expired) next_state = IDLE;
            READ_REQ:  begin
                           oe0        = 1'b1;
                           next_state = READ_WAIT;
                       end
            READ_WAIT: if (Sout_DataRdy[0]) next_state = READ_OUT;
            READ_OUT:  if (rd_ready) next_state = (idx_inc == read_len_q) ? DONE : READ_REQ;
            DONE:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    assign cfg_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign load_ready = (state == LOAD);
    assign start_port = (state == START);
    assign rd_valid   = (state == READ_OUT);
    assign run_done   = (state == DONE);

    // Address, data and size lanes are only driven while an access is in flight.
    assign S_we_ram        = {1'b0, we0};
    assign S_oe_ram        = {1'b0, oe0};
    assign S_addr_ram      = {{CH_ADDR_W{1'b0}}, (we0 | oe0) ? ch0_addr : {CH_ADDR_W{1'b0}}};
    assign S_Wdata_ram     = {{CH_DATA_W{1'b0}}, we0 ? load_data : {CH_DATA_W{1'b0}}};
    assign S_data_ram_size = {{CH_SIZE_W{1'b0}}, (we0 | oe0) ? CH_SIZE_W'(CH_DATA_W) : {CH_SIZE_W{1'b0}}};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            base_q       <= '0;
            load_len_q   <= '0;
            read_len_q   <= '0;
            idx          <= '0;
            wdog         <= '0;
            cycle_count  <= '0;
            timeout_flag <= 1'b0;
            rd_data      <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: if (cfg_valid) begin
                    base_q       <= cfg_base;
                    load_len_q   <= cfg_load_len;
                    read_len_q   <= cfg_read_len;
                    idx          <= '0;
                    timeout_flag <= 1'b0;
                end
                LOAD_WAIT: if (Sout_DataRdy[0]) idx <= idx_inc;
                START:     wdog <= '0;
                RUN: begin
                    if (done_port) begin
                        cycle_count <= wdog + 32'd1;
                        idx         <= '0;
                    end else begin
                        wdog <= wdog + 32'd1;
                        if (wdog_expired) timeout_flag <= 1'b1;
                    end
                end
                READ_WAIT: if (Sout_DataRdy[0]) rd_data <= Sout_Rdata_ram[CH_DATA_W-1:0];
                READ_OUT:  if (rd_ready) idx <= idx_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hls_run_sequencer.sv
// tb/tb_hls_run_sequencer.sv - self-checking bench for hls_run_sequencer with slave RAM and accelerator models
module tb_hls_run_sequencer;

    typedef logic [7:0] bq_t[$];

    logic        clock = 1'b0;
    logic        reset;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [6:0]  cfg_base = '0;
    logic [15:0] cfg_load_len = '0;
    logic [15:0] cfg_read_len = '0;
    logic [7:0]  load_data = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic        start_port;
    logic        done_port;
    logic [1:0]  S_oe_ram, S_we_ram;
    logic [13:0] S_addr_ram;
    logic [15:0] S_Wdata_ram;
    logic [7:0]  S_data_ram_size;
    logic [15:0] Sout_Rdata_ram;
    logic [1:0]  Sout_DataRdy;
    logic        busy, run_done, timeout_flag;
    logic [31:0] cycle_count;

    int checks = 0;
    int failures = 0;

    hls_run_sequencer #(.CH_ADDR_W(7), .CH_DATA_W(8), .CH_SIZE_W(4), .TIMEOUT_CYC(16)) dut (
        .clock(clock), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_base(cfg_base),
        .cfg_load_len(cfg_load_len), .cfg_read_len(cfg_read_len),
        .load_data(load_data), .load_valid(load_valid), .load_ready(load_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .start_port(start_port), .done_port(done_port),
        .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
        .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
        .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
        .busy(busy), .run_done(run_done), .timeout_flag(timeout_flag), .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    // Slave RAM: completes every access one cycle after it is issued.
    logic [7:0] mem [0:127];
    logic       slv_rdy;
    logic [7:0] slv_rdata;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            slv_rdy   <= 1'b0;
            slv_rdata <= 8'h00;
        end else begin
            slv_rdy <= S_we_ram[0] | S_oe_ram[0];
            if (S_we_ram[0]) mem[S_addr_ram[6:0]] <= S_Wdata_ram[7:0];
            if (S_oe_ram[0]) slv_rdata <= mem[S_addr_ram[6:0]];
        end
    end
    assign Sout_Rdata_ram = {8'hC3, slv_rdata};
    assign Sout_DataRdy   = {1'b0, slv_rdy};

    // Accelerator: done_port high on RUN cycle number done_at (0 = never).
    int acc_cnt;
    int done_at = 0;
    always @(posedge clock or posedge reset) begin
        if (reset)             acc_cnt <= 0;
        else if (start_port)   acc_cnt <= 1;
        else if (acc_cnt != 0) acc_cnt <= acc_cnt + 1;
    end
    assign done_port = (done_at != 0) && (acc_cnt == done_at);

    // Bus monitor
    logic [14:0] wr_q[$];
    int we_cnt = 0, oe_cnt = 0, start_cnt = 0, done_cnt = 0;
    int ch1_viol = 0, both_viol = 0, size_viol = 0;
    always @(posedge clock) begin
        if (!reset) begin
            if (S_we_ram[0]) begin
                wr_q.push_back({S_addr_ram[6:0], S_Wdata_ram[7:0]});
                we_cnt <= we_cnt + 1;
            end
            if (S_oe_ram[0]) oe_cnt <= oe_cnt + 1;
            if ((S_we_ram[0] | S_oe_ram[0]) && S_data_ram_size[3:0] != 4'd8) size_viol <= size_viol + 1;
            if (S_we_ram[1] | S_oe_ram[1] | (S_addr_ram[13:7] != 0) | (S_Wdata_ram[15:8] != 0) | (S_data_ram_size[7:4] != 0))
                ch1_viol <= ch1_viol + 1;
            if (S_we_ram[0] & S_oe_ram[0]) both_viol <= both_viol + 1;
            if (start_port) start_cnt <= start_cnt + 1;
            if (run_done)   done_cnt  <= done_cnt + 1;
        end
    end

    task automatic drive_run(input logic [6:0] base, input bq_t bytes, input int rlen, input int dat,
                             input int stall_at, input int stall_n,
                             output bq_t got, output int stall_bad, output int runlen, output int ok);
        int li = 0, ri = 0, sc = 0, k = -1;
        logic [7:0] held = 8'h00;
        got = {}; stall_bad = 0; runlen = -1; ok = 0;
        done_at = dat;
        @(negedge clock);
        cfg_valid = 1'b1; cfg_base = base;
        cfg_load_len = 16'(bytes.size()); cfg_read_len = 16'(rlen);
        @(negedge clock);
        cfg_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (start_port) k = 0;
            else if (k >= 0) k++;
            if (!busy) begin
                ok = 1; runlen = k;
                break;
            end
            load_valid = load_ready && (li < bytes.size()) && ($urandom_range(0, 3) != 0);
            load_data  = load_valid ? bytes[li] : 8'($urandom);
            if (load_valid) li++;
            if (rd_valid) begin
                if (sc > 0 && ri == stall_at && rd_data !== held) stall_bad++;
                if (ri == stall_at && sc < stall_n) begin
                    held = rd_data; rd_ready = 1'b0; sc++;
                end else begin
                    rd_ready = 1'b1; got.push_back(rd_data); ri++;
                end
            end else rd_ready = 1'b0;
            @(negedge clock);
        end
        load_valid = 1'b0; rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({cfg_ready, busy, load_ready, rd_valid, start_port, run_done, timeout_flag} !== 7'b1000000) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=1000000", {cfg_ready, busy, load_ready, rd_valid, start_port, run_done, timeout_flag});
        end
        checks++;
        if ({S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size, rd_data, cycle_count} !== '0) begin
            failures++; $display("FAIL reset_data got=%h exp=0", {S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size, rd_data, cycle_count});
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({cfg_ready, busy} !== 2'b10) begin failures++; $display("FAIL reset_release got=%b exp=10", {cfg_ready, busy}); end
    endtask

    task automatic test_load_wrap_and_run();
        bq_t got; int sb, rl, ok, we0, st0, dn0, oe0;
        logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [6:0] exp_a [4] = '{7'h7E, 7'h7F, 7'h00, 7'h01};
        wr_q.delete();
        we0 = we_cnt; st0 = start_cnt; dn0 = done_cnt; oe0 = oe_cnt;
        drive_run(7'h7E, '{8'h11, 8'h22, 8'h33, 8'h44}, 0, 10, -1, 0, got, sb, rl, ok);
        checks++;
        if (ok !== 1) begin failures++; $display("FAIL load_run_timeout got=%0d exp=1", ok); end
        checks++;
        if (wr_q.size() !== 4) begin failures++; $display("FAIL load_write_count got=%0d exp=4", wr_q.size()); end
        for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== {exp_a[i], exp_d[i]}) begin
                failures++; $display("FAIL load_write%0d got=%h exp=%h", i, wr_q[i], {exp_a[i], exp_d[i]});
            end
        end
        checks++;
        if (we_cnt - we0 !== 4) begin failures++; $display("FAIL load_we_cycles got=%0d exp=4", we_cnt - we0); end
        checks++;
        if ({ch1_viol, both_viol, size_viol} !== 96'd0) begin
            failures++; $display("FAIL load_lanes got=%0d/%0d/%0d exp=0/0/0", ch1_viol, both_viol, size_viol);
        end
        checks++;
        if (start_cnt - st0 !== 1) begin failures++; $display("FAIL run_start_pulses got=%0d exp=1", start_cnt - st0); end
        checks++;
        if (cycle_count !== 32'd10) begin failures++; $display("FAIL run_cycle_count got=%0d exp=10", cycle_count); end
        checks++;
        if (done_cnt - dn0 !== 1) begin failures++; $display("FAIL run_done_pulses got=%0d exp=1", done_cnt - dn0); end
        checks++;
        if (oe_cnt - oe0 !== 0) begin failures++; $display("FAIL run_no_read got=%0d exp=0", oe_cnt - oe0); end
    endtask

    task automatic test_read_stall();
        bq_t got; int sb, rl, ok, oe0;
        logic [7:0] exp_d [3] = '{8'hA5, 8'h5A, 8'hFF};
        oe0 = oe_cnt;
        drive_run(7'($urandom), '{8'hA5, 8'h5A, 8'hFF}, 3, 3, 1, 5, got, sb, rl, ok);
        checks++;
        if (got.size() !== 3 || ok !== 1) begin failures++; $display("FAIL read_count got=%0d exp=3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_d[i]) begin failures++; $display("FAIL read_byte%0d got=%h exp=%h", i, got[i], exp_d[i]); end
        end
        checks++;
        if (sb !== 0) begin failures++; $display("FAIL read_stall_stable got=%0d exp=0", sb); end
        checks++;
        if (oe_cnt - oe0 !== 3) begin failures++; $display("FAIL read_oe_cycles got=%0d exp=3", oe_cnt - oe0); end
    endtask

    task automatic test_zero_len();
        bq_t got; int sb, rl, ok, we0, oe0, dn0;
        we0 = we_cnt; oe0 = oe_cnt; dn0 = done_cnt;
        drive_run(7'($urandom), '{}, 0, 1, -1, 0, got, sb, rl, ok);
        checks++;
        if ((we_cnt - we0) + (oe_cnt - oe0) !== 0) begin
            failures++; $display("FAIL zero_no_access got=%0d exp=0", (we_cnt - we0) + (oe_cnt - oe0));
        end
        checks++;
        if (cycle_count !== 32'd1) begin failures++; $display("FAIL zero_cycle_count got=%0d exp=1", cycle_count); end
        checks++;
        if (done_cnt - dn0 !== 1 || ok !== 1) begin failures++; $display("FAIL zero_done got=%0d exp=1", done_cnt - dn0); end
    endtask

    task automatic test_timeout();
        bq_t got; int sb, rl, ok, oe0, dn0;
        oe0 = oe_cnt; dn0 = done_cnt;
        drive_run(7'h10, '{8'h01, 8'h02}, 2, 0, -1, 0, got, sb, rl, ok);
        checks++;
        if (timeout_flag !== 1'b1) begin failures++; $display("FAIL timeout_flag got=%b exp=1", timeout_flag); end
        checks++;
        if (rl !== 17) begin failures++; $display("FAIL timeout_idle_cycle got=%0d exp=17", rl); end
        checks++;
        if (oe_cnt - oe0 !== 0 || done_cnt - dn0 !== 0) begin
            failures++; $display("FAIL timeout_no_read got=%0d/%0d exp=0/0", oe_cnt - oe0, done_cnt - dn0);
        end
        drive_run(7'h20, '{}, 0, 2, -1, 0, got, sb, rl, ok);
        checks++;
        if (timeout_flag !== 1'b0) begin failures++; $display("FAIL timeout_cleared got=%b exp=0", timeout_flag); end
        checks++;
        if (cycle_count !== 32'd2) begin failures++; $display("FAIL timeout_next_count got=%0d exp=2", cycle_count); end
    endtask

    task automatic test_reset_mid_read();
        bq_t got; int sb, rl, ok, seen = 0;
        done_at = 1;
        @(negedge clock);
        cfg_valid = 1'b1; cfg_base = 7'h05; cfg_load_len = 16'd0; cfg_read_len = 16'd2;
        @(negedge clock);
        cfg_valid = 1'b0;
        for (int c = 0; c < 50 && seen == 0; c++) begin
            if (S_oe_ram[0]) seen = 1;
            @(negedge clock);
        end
        checks++;
        if (seen !== 1) begin failures++; $display("FAIL midreset_reach got=%0d exp=1", seen); end
        reset = 1'b1;
        #1;
        checks++;
        if ({cfg_ready, busy, load_ready, rd_valid, start_port, run_done, S_oe_ram, S_we_ram} !== 10'b1000000000) begin
            failures++; $display("FAIL midreset_outputs got=%b exp=1000000000", {cfg_ready, busy, load_ready, rd_valid, start_port, run_done, S_oe_ram, S_we_ram});
        end
        checks++;
        if ({S_addr_ram, rd_data, cycle_count} !== '0) begin
            failures++; $display("FAIL midreset_data got=%h exp=0", {S_addr_ram, rd_data, cycle_count});
        end
        @(negedge clock);
        reset = 1'b0;
        drive_run(7'h40, '{8'h9C, 8'h3D}, 2, 4, -1, 0, got, sb, rl, ok);
        checks++;
        if (got.size() !== 2 || got[0] !== 8'h9C || got[1] !== 8'h3D) begin
            failures++; $display("FAIL midreset_rerun got=%p exp=9c,3d", got);
        end
        checks++;
        if (cycle_count !== 32'd4) begin failures++; $display("FAIL midreset_count got=%0d exp=4", cycle_count); end
    endtask

    task automatic test_random_runs();
        for (int it = 0; it < 8; it++) begin
            bq_t bytes, got; int sb, rl, ok, n, rlen, dat, st0, dn0, oe0;
            logic [6:0] base;
            base = 7'($urandom);
            n    = $urandom_range(1, 6);
            rlen = $urandom_range(0, n);
            dat  = $urandom_range(1, 14);
            for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
            wr_q.delete();
            st0 = start_cnt; dn0 = done_cnt; oe0 = oe_cnt;
            drive_run(base, bytes, rlen, dat, $urandom_range(0, n), $urandom_range(0, 4), got, sb, rl, ok);
            checks++;
            if (wr_q.size() !== n) begin failures++; $display("FAIL rnd%0d_writes got=%0d exp=%0d", it, wr_q.size(), n); end
            for (int i = 0; i < n && i < wr_q.size(); i++) begin
                checks++;
                if (wr_q[i] !== {7'((int'(base) + i) % 128), bytes[i]}) begin
                    failures++; $display("FAIL rnd%0d_wr%0d got=%h exp=%h", it, i, wr_q[i], {7'((int'(base) + i) % 128), bytes[i]});
                end
            end
            checks++;
            if (got.size() !== rlen) begin failures++; $display("FAIL rnd%0d_reads got=%0d exp=%0d", it, got.size(), rlen); end
            for (int i = 0; i < rlen && i < got.size(); i++) begin
                checks++;
                if (got[i] !== bytes[i]) begin failures++; $display("FAIL rnd%0d_rd%0d got=%h exp=%h", it, i, got[i], bytes[i]); end
            end
            checks++;
            if (cycle_count !== 32'(dat) || sb !== 0) begin
                failures++; $display("FAIL rnd%0d_count got=%0d exp=%0d stall=%0d", it, cycle_count, dat, sb);
            end
            checks++;
            if (start_cnt - st0 !== 1 || done_cnt - dn0 !== 1 || oe_cnt - oe0 !== rlen) begin
                failures++; $display("FAIL rnd%0d_pulses got=%0d/%0d/%0d exp=1/1/%0d", it, start_cnt - st0, done_cnt - dn0, oe_cnt - oe0, rlen);
            end
        end
        checks++;
        if ({ch1_viol, both_viol, size_viol} !== 96'd0) begin
            failures++; $display("FAIL rnd_lanes got=%0d/%0d/%0d exp=0/0/0", ch1_viol, both_viol, size_viol);
        end
    endtask

    initial begin
        test_reset();
        test_load_wrap_and_run();
        test_read_stall();
        test_zero_len();
        test_timeout();
        test_reset_mid_read();
        test_random_runs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hls_run_sequencer.md
Name: hls_run_sequencer

Overview:
Controller that runs one Bambu-generated accelerator (`main`-style top with a 2-channel slave RAM port and a start_port/done_port handshake) end to end. For each run it:
- preloads input bytes into accelerator memory through slave channel 0;
- pulses start_port and waits for done_port, counting latency and enforcing a watchdog;
- streams result bytes back out of accelerator memory.

It replaces file-driven testbench sequencing, so on-board runs and regressions share one synthesizable sequencer.

Parameters:
- CH_ADDR_W, 7, address bits per slave channel; the S_addr_ram width is 2*CH_ADDR_W.
- CH_DATA_W, 8, data bits per slave channel; the S_Wdata_ram and Sout_Rdata_ram width is 2*CH_DATA_W.
- CH_SIZE_W, 4, size-field bits per slave channel; the S_data_ram_size width is 2*CH_SIZE_W.
- TIMEOUT_CYC, 200000000, maximum number of RUN cycles before a timeout abort.

Ports:
- clock, in, 1: the single clock; all logic is on the rising edge.
- reset, in, 1: asynchronous, active-high.
- cfg_valid / cfg_ready, in / out, 1 each: run-request handshake.
- cfg_base, in, CH_ADDR_W: accelerator base address for both load and read.
- cfg_load_len, in, 16: number of bytes to preload.
- cfg_read_len, in, 16: number of bytes to read back.
- load_data, in, CH_DATA_W: input byte stream.
- load_valid / load_ready, in / out, 1 each: input stream handshake.
- rd_data, out, CH_DATA_W: result byte stream.
- rd_valid / rd_ready, out / in, 1 each: result stream handshake.
- start_port, out, 1: accelerator start pulse.
- done_port, in, 1: accelerator completion.
- S_oe_ram, out, 2: slave read enables.
- S_we_ram, out, 2: slave write enables.
- S_addr_ram, out, 2*CH_ADDR_W: slave addresses.
- S_Wdata_ram, out, 2*CH_DATA_W: slave write data.
- S_data_ram_size, out, 2*CH_SIZE_W: slave access size in bits.
- Sout_Rdata_ram, in, 2*CH_DATA_W: slave read data.
- Sout_DataRdy, in, 2: slave access completion.
- busy, out, 1: high in every state except IDLE.
- run_done, out, 1: one-cycle pulse on successful completion.
- timeout_flag, out, 1: sticky; set on timeout abort.
- cycle_count, out, 32: accelerator latency of the last run.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE.
  - Every output is 0, except cfg_ready = 1.
  - The byte index, watchdog counter and cycle_count are all 0.
- Slave channel 1 lanes (the upper half of every S_* vector) are always driven 0.
- Slave channel 0 access fields:
  - address = (cfg_base + idx) mod 2^CH_ADDR_W; wrap-around is silent.
  - size field = CH_DATA_W (8).
  - S_oe_ram and S_we_ram are never high in the same cycle.
- State IDLE:
  - cfg_ready = 1.
  - On cfg_valid, latch base and both lengths, clear timeout_flag and idx.
  - Next state is LOAD if load_len > 0, else START.
- State LOAD:
  - load_ready = 1.
  - On load_valid, drive S_we_ram[0] = 1 with address(idx) and load_data for exactly that cycle, then go to LOAD_WAIT.
- State LOAD_WAIT:
  - load_ready = 0 and the slave port is idle.
  - On Sout_DataRdy[0], idx++.
  - Next state is START if idx == load_len, else LOAD.
- State START:
  - start_port = 1 for exactly one cycle.
  - Clear the watchdog counter; go to RUN.
- State RUN:
  - done_port is sampled only in RUN.
  - If done_port = 0, the counter increments.
  - If done_port = 1, cycle_count = counter + 1 (so done in the first RUN cycle gives 1).
  - After done: clear idx and go to READ_REQ if read_len > 0, else DONE.
  - If the counter reaches TIMEOUT_CYC without done: set timeout_flag and go to IDLE. No readback is performed.
- State READ_REQ:
  - S_oe_ram[0] = 1 with address(idx) for exactly one cycle; go to READ_WAIT.
- State READ_WAIT:
  - On Sout_DataRdy[0], register Sout_Rdata_ram[CH_DATA_W-1:0] into rd_data, set rd_valid, go to READ_OUT.
- State READ_OUT:
  - rd_valid and rd_data are held stable until rd_ready.
  - On the transfer: rd_valid = 0, idx++.
  - Next state is DONE if idx == read_len, else READ_REQ.
- State DONE:
  - run_done = 1 for one cycle; go to IDLE.
- Simultaneous events:
  - cfg_valid is ignored outside IDLE.
  - Sout_DataRdy is ignored outside LOAD_WAIT and READ_WAIT.
  - done_port high during START is ignored; only RUN samples it.
- Throughput: at most one slave access is outstanding; one byte per two cycles at best.
- Reset mid-operation: all outputs return to reset values immediately; any partial load or read is abandoned.

Test Plan:
1. Load length 4 with bytes 0x11,0x22,0x33,0x44, base 0x7E; DataRdy returned 1 cycle after each write:
   - writes go to addresses 0x7E, 0x7F, 0x00, 0x01 (wrap);
   - S_we_ram = 2'b01 for a single cycle per byte;
   - channel 1 lanes stay 0.
2. After the load, done_port rises on the 10th RUN cycle -> start_port high for exactly 1 cycle, cycle_count = 10, run_done pulses once.
3. Read length 3, slave returns 0xA5, 0x5A, 0xFF; rd_ready held low for 5 cycles on the 2nd byte -> rd_data stable while stalled; the stream is 0xA5, 0x5A, 0xFF.
4. Load length 0 and read length 0; done_port in the first RUN cycle -> no slave access at all, cycle_count = 1, run_done pulses.
5. TIMEOUT_CYC = 16 and done_port never rises -> timeout_flag = 1 after 16 RUN cycles, return to IDLE, no S_oe_ram pulse. A following cfg_valid clears the flag.
6. Assert reset during READ_WAIT -> all outputs are 0 and cfg_ready = 1 in the same cycle; a new run then completes normally.
